// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb_if
// Brief    : Requester/transmitter signal bundle for the uart_tx arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arb_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ack;
   logic [NREQ-1:0]   grant;
   logic [7:0]        tx_data;
   logic              tx_write;
   logic              tx_ready;
   logic              busy;
   logic              err_timeout;

   // master: requesters plus the uart_tx; slave: the arbiter
   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ack, grant, tx_data, tx_write, busy, err_timeout
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ack, grant, tx_data, tx_write, busy, err_timeout
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Message-atomic round-robin arbiter sharing one uart_tx among
//            NREQ byte streams, with a stalled-grant timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 65535
) (
   input  wire          clk,
   input  wire          reset_n,
   uart_tx_arb_if.slave bus
);

   localparam int                 c_PTR_W    = $clog2(NREQ);
   localparam int                 c_IDX_W    = c_PTR_W + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_RST  = c_PTR_W'(NREQ - 1);
   localparam logic [15:0]        c_CNT_LAST = 16'(TIMEOUT - 1);
   localparam logic [NREQ-1:0]    c_ONE      = NREQ'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HOLD    = 3'd1,
      S_SEND    = 3'd2,
      S_WAIT_LO = 3'd3,
      S_WAIT_HI = 3'd4
   } state_t;

   state_t               r_state,    w_state;
   logic [NREQ-1:0]      r_grant,    w_grant;
   logic [c_PTR_W-1:0]   r_owner,    w_owner;
   logic [c_PTR_W-1:0]   r_ptr,      w_ptr;
   logic [15:0]          r_cnt,      w_cnt;
   logic                 r_last,     w_last;
   logic [NREQ-1:0]      r_ack,      w_ack;
   logic [7:0]           r_tx_data,  w_tx_data;
   logic                 r_tx_write, w_tx_write;
   logic                 r_busy,     w_busy;
   logic                 r_err,      w_err;
   logic [c_IDX_W-1:0]   w_pick;

   // Returns {found, index} of the first valid requester after p, wrapping.
   // Scanning from the farthest candidate down lets the nearest one win.
   function automatic logic [c_IDX_W-1:0] rr_pick(input logic [NREQ-1:0]    v,
                                                  input logic [c_PTR_W-1:0] p);
      logic [c_IDX_W-1:0] res;
      logic [c_IDX_W-1:0] idx;
      res = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = {1'b0, p} + c_IDX_W'(k);
         if (idx >= c_IDX_W'(NREQ)) begin
            idx = idx - c_IDX_W'(NREQ);
         end
         if (v[idx[c_PTR_W-1:0]]) begin
            res = {1'b1, idx[c_PTR_W-1:0]};
         end
      end
      return res;
   endfunction

   assign w_pick = rr_pick(bus.req_valid, r_ptr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_owner    <= '0;
         r_ptr      <= c_PTR_RST;
         r_cnt      <= '0;
         r_last     <= 1'b0;
         r_ack      <= '0;
         r_tx_data  <= '0;
         r_tx_write <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_grant    <= w_grant;
         r_owner    <= w_owner;
         r_ptr      <= w_ptr;
         r_cnt      <= w_cnt;
         r_last     <= w_last;
         r_ack      <= w_ack;
         r_tx_data  <= w_tx_data;
         r_tx_write <= w_tx_write;
         r_busy     <= w_busy;
         r_err      <= w_err;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_grant    = r_grant;
      w_owner    = r_owner;
      w_ptr      = r_ptr;
      w_cnt      = r_cnt;
      w_last     = r_last;
      w_tx_data  = r_tx_data;
      w_ack      = '0;
      w_tx_write = 1'b0;
      w_err      = 1'b0;

      case (r_state)
         S_IDLE: begin
            // tx_ready gating keeps a frame in flight across reset intact
            if (w_pick[c_IDX_W-1] && bus.tx_ready) begin
               w_state = S_HOLD;
               w_owner = w_pick[c_PTR_W-1:0];
               w_grant = c_ONE << w_pick[c_PTR_W-1:0];
               w_cnt   = '0;
            end
         end

         S_HOLD: begin
            if (bus.req_valid[r_owner]) begin
               // A valid byte always beats an expiring timeout
               if (bus.tx_ready) begin
                  w_state    = S_SEND;
                  w_tx_data  = bus.req_data[{r_owner, 3'b000} +: 8];
                  w_last     = bus.req_last[r_owner];
                  w_tx_write = 1'b1;
                  w_ack      = c_ONE << r_owner;
               end
            end else if (r_cnt == c_CNT_LAST) begin
               w_state = S_IDLE;
               w_grant = '0;
               w_ptr   = r_owner;
               w_err   = 1'b1;
            end else begin
               w_cnt = r_cnt + 16'd1;
            end
         end

         S_SEND: begin
            w_state = S_WAIT_LO;
         end

         S_WAIT_LO: begin
            if (!bus.tx_ready) begin
               w_state = S_WAIT_HI;
            end
         end

         S_WAIT_HI: begin
            if (bus.tx_ready) begin
               if (r_last) begin
                  w_state = S_IDLE;
                  w_grant = '0;
                  w_ptr   = r_owner;
               end else begin
                  w_state = S_HOLD;
                  w_cnt   = '0;
               end
            end
         end

         default: begin
            w_state = S_IDLE;
            w_grant = '0;
         end
      endcase

      w_busy = |w_grant;
   end

   assign bus.req_ack     = r_ack;
   assign bus.grant       = r_grant;
   assign bus.tx_data     = r_tx_data;
   assign bus.tx_write    = r_tx_write;
   assign bus.busy        = r_busy;
   assign bus.err_timeout = r_err;

endmodule
`default_nettype wire
